// File: rtl/vga_pkg.sv
// Shared VGA pixel-path types, default field geometry and colour helpers.
package vga_pkg;

  typedef logic [14:0] rgb555_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam int COL_W     = 12;
  localparam int ROW_W     = 11;
  localparam int HOR_FIELD = 1279;
  localparam int VER_FIELD = 1023;

  // Low bits are zero-filled, so full-scale 5-bit becomes F8, not FF.
  function automatic rgb888_t expand_rgb555(input rgb555_t c);
    rgb888_t p;
    p.r = {c[14:10], 3'b000};
    p.g = {c[9:5],   3'b000};
    p.b = {c[4:0],   3'b000};
    return p;
  endfunction

endpackage

// File: rtl/sprite_hit.sv
// Combinational hit test for one square sprite against the current pixel.
module sprite_hit #(
  parameter int SIZE  = 32,
  parameter int COL_W = 12,
  parameter int ROW_W = 11
) (
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] x,
  input  logic [ROW_W-1:0] y,
  input  logic             en,
  output logic             hit
);

  localparam logic [COL_W:0] SIZE_C = (COL_W+1)'(SIZE);
  localparam logic [ROW_W:0] SIZE_R = (ROW_W+1)'(SIZE);

  // One extra bit on the upper bound keeps sprites near the far edge from wrapping to 0.
  logic [COL_W:0] col_e, x_lo, x_hi;
  logic [ROW_W:0] row_e, y_lo, y_hi;

  assign col_e = {1'b0, col};
  assign x_lo  = {1'b0, x};
  assign x_hi  = x_lo + SIZE_C;
  assign row_e = {1'b0, row};
  assign y_lo  = {1'b0, y};
  assign y_hi  = y_lo + SIZE_R;

  assign hit = en && (col_e >= x_lo) && (col_e < x_hi) && (row_e >= y_lo) && (row_e < y_hi);

endmodule

// File: rtl/vga_sprite_compositor.sv
// Two-stage pixel path compositing prioritised sprites over a tinted checkerboard,
// with frame-synchronous position updates and per-frame collision reporting.
module vga_sprite_compositor #(
  parameter int NUM_SPRITES = 4,
  parameter int SIZE        = 32,
  parameter int COL_W       = vga_pkg::COL_W,
  parameter int ROW_W       = vga_pkg::ROW_W,
  parameter int CHECKER_BIT = 7
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [COL_W-1:0]             display_col,
  input  logic [ROW_W-1:0]             display_row,
  input  logic                         visible,
  input  logic                         hsync,
  input  logic                         vsync,
  input  logic [NUM_SPRITES*COL_W-1:0] sprite_x,
  input  logic [NUM_SPRITES*ROW_W-1:0] sprite_y,
  input  logic [NUM_SPRITES*15-1:0]    sprite_color,
  input  logic [NUM_SPRITES-1:0]       sprite_en,
  input  logic [8:0]                   bg_tint,
  output logic [7:0]                   vga_r,
  output logic [7:0]                   vga_g,
  output logic [7:0]                   vga_b,
  output logic                         vga_hs,
  output logic                         vga_vs,
  output logic                         vga_blank_n,
  output logic [NUM_SPRITES-1:0]       collision,
  output logic                         frame_tick
);

  import vga_pkg::*;

  logic [NUM_SPRITES*COL_W-1:0] act_x;
  logic [NUM_SPRITES*ROW_W-1:0] act_y;
  logic [NUM_SPRITES-1:0]       act_en;
  logic [NUM_SPRITES-1:0]       hit_now;
  logic [NUM_SPRITES-1:0]       hit_q;
  logic [NUM_SPRITES-1:0]       coll_acc;
  logic                         vs_prev;
  logic                         boundary;
  logic                         multi_hit;
  logic                         vis_q, hs_q, vs_q, chk_q;
  logic                         sel_found;
  rgb555_t                      sel_color;
  rgb888_t                      pix;

  assign boundary  = vs_prev & ~vsync;
  // Clearing the lowest set bit leaves something only when two or more sprites hit.
  assign multi_hit = |(hit_now & (hit_now - NUM_SPRITES'(1)));

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
    sprite_hit #(
      .SIZE  (SIZE),
      .COL_W (COL_W),
      .ROW_W (ROW_W)
    ) u_hit (
      .col (display_col),
      .row (display_row),
      .x   (act_x[i*COL_W +: COL_W]),
      .y   (act_y[i*ROW_W +: ROW_W]),
      .en  (act_en[i]),
      .hit (hit_now[i])
    );
  end

  // vs_prev resets low so a reset released during vsync cannot fake a frame boundary.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev    <= 1'b0;
      act_x      <= '0;
      act_y      <= '0;
      act_en     <= '0;
      coll_acc   <= '0;
      collision  <= '0;
      frame_tick <= 1'b0;
    end else begin
      vs_prev    <= vsync;
      frame_tick <= boundary;
      if (boundary) begin
        act_x     <= sprite_x;
        act_y     <= sprite_y;
        act_en    <= sprite_en;
        collision <= coll_acc;
        coll_acc  <= '0;
      end else if (visible && multi_hit) begin
        coll_acc  <= coll_acc | hit_now;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vis_q <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      chk_q <= 1'b0;
      hit_q <= '0;
    end else begin
      vis_q <= visible;
      hs_q  <= hsync;
      vs_q  <= vsync;
      chk_q <= display_row[CHECKER_BIT] ^ display_col[CHECKER_BIT];
      hit_q <= hit_now;
    end
  end

  // Descending scan so the lowest hitting index is the last one written.
  always_comb begin
    sel_found = 1'b0;
    sel_color = '0;
    for (int i = NUM_SPRITES-1; i >= 0; i--) begin
      if (hit_q[i]) begin
        sel_found = 1'b1;
        sel_color = sprite_color[i*15 +: 15];
      end
    end
    if (sel_found) begin
      pix = expand_rgb555(sel_color);
    end else begin
      pix.r = {bg_tint[8:6], {5{chk_q}}};
      pix.g = {bg_tint[5:3], {5{chk_q}}};
      pix.b = {bg_tint[2:0], {5{chk_q}}};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else begin
      vga_r       <= vis_q ? pix.r : 8'h00;
      vga_g       <= vis_q ? pix.g : 8'h00;
      vga_b       <= vis_q ? pix.b : 8'h00;
      vga_hs      <= hs_q;
      vga_vs      <= vs_q;
      vga_blank_n <= vis_q;
    end
  end

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Randomised and directed bench for vga_sprite_compositor against a pixel-level reference model.
module tb_vga_sprite_compositor;

  localparam int NS    = 4;
  localparam int SIZE  = 32;
  localparam int COL_W = 12;
  localparam int ROW_W = 11;
  localparam int CB    = 7;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [COL_W-1:0]      display_col;
  logic [ROW_W-1:0]      display_row;
  logic                  visible, hsync, vsync;
  logic [NS*COL_W-1:0]   sprite_x;
  logic [NS*ROW_W-1:0]   sprite_y;
  logic [NS*15-1:0]      sprite_color;
  logic [NS-1:0]         sprite_en;
  logic [8:0]            bg_tint;
  logic [7:0]            vga_r, vga_g, vga_b;
  logic                  vga_hs, vga_vs, vga_blank_n;
  logic [NS-1:0]         collision;
  logic                  frame_tick;

  vga_sprite_compositor #(
    .NUM_SPRITES (NS),
    .SIZE        (SIZE),
    .COL_W       (COL_W),
    .ROW_W       (ROW_W),
    .CHECKER_BIT (CB)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .display_col  (display_col),
    .display_row  (display_row),
    .visible      (visible),
    .hsync        (hsync),
    .vsync        (vsync),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .sprite_color (sprite_color),
    .sprite_en    (sprite_en),
    .bg_tint      (bg_tint),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .vga_hs       (vga_hs),
    .vga_vs       (vga_vs),
    .vga_blank_n  (vga_blank_n),
    .collision    (collision),
    .frame_tick   (frame_tick)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] r, g, b;
    logic       hs, vs, bn;
  } pix_t;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_cnt = 0;

  int            m_x [NS];
  int            m_y [NS];
  bit            m_en[NS];
  bit            m_vsp;
  logic [NS-1:0] m_acc, m_coll;
  bit            m_tick;
  pix_t          e_prev, exp_o;
  logic [NS-1:0] m_h;
  logic [14:0]   m_c;
  bit            m_found, m_chk;

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NS-1:0] hits_of(int c, int r);
    logic [NS-1:0] h;
    h = '0;
    for (int i = 0; i < NS; i++)
      h[i] = m_en[i] && (c >= m_x[i]) && (c < m_x[i] + SIZE) && (r >= m_y[i]) && (r < m_y[i] + SIZE);
    return h;
  endfunction

  // Reference model: one pixel per edge, outputs expected one edge later; collisions immediate.
  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NS; i++) begin
        m_x[i] = 0; m_y[i] = 0; m_en[i] = 0;
      end
      m_vsp  = 0;
      m_acc  = '0;
      m_coll = '0;
      m_tick = 0;
      e_prev = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
      exp_o  = e_prev;
    end else begin
      exp_o = e_prev;
      m_h = hits_of(int'(display_col), int'(display_row));
      e_prev.hs = hsync;
      e_prev.vs = vsync;
      e_prev.bn = visible;
      m_found = 0;
      m_c = '0;
      for (int i = 0; i < NS; i++)
        if (m_h[i] && !m_found) begin
          m_found = 1;
          m_c = sprite_color[i*15 +: 15];
        end
      m_chk = display_row[CB] ^ display_col[CB];
      if (!visible) begin
        e_prev.r = 8'h00; e_prev.g = 8'h00; e_prev.b = 8'h00;
      end else if (m_found) begin
        e_prev.r = {m_c[14:10], 3'b000};
        e_prev.g = {m_c[9:5], 3'b000};
        e_prev.b = {m_c[4:0], 3'b000};
      end else begin
        e_prev.r = {bg_tint[8:6], {5{m_chk}}};
        e_prev.g = {bg_tint[5:3], {5{m_chk}}};
        e_prev.b = {bg_tint[2:0], {5{m_chk}}};
      end
      if (m_vsp && !vsync) begin
        m_tick = 1;
        m_coll = m_acc;
        m_acc  = '0;
        for (int i = 0; i < NS; i++) begin
          m_x[i]  = int'(sprite_x[i*COL_W +: COL_W]);
          m_y[i]  = int'(sprite_y[i*ROW_W +: ROW_W]);
          m_en[i] = sprite_en[i];
        end
      end else begin
        m_tick = 0;
        if (visible && $countones(m_h) >= 2) m_acc = m_acc | m_h;
      end
      m_vsp = vsync;
    end
    #1;
    cmp("vga_r", 32'(vga_r), 32'(exp_o.r));
    cmp("vga_g", 32'(vga_g), 32'(exp_o.g));
    cmp("vga_b", 32'(vga_b), 32'(exp_o.b));
    cmp("vga_hs", 32'(vga_hs), 32'(exp_o.hs));
    cmp("vga_vs", 32'(vga_vs), 32'(exp_o.vs));
    cmp("vga_blank_n", 32'(vga_blank_n), 32'(exp_o.bn));
    cmp("collision", 32'(collision), 32'(m_coll));
    cmp("frame_tick", 32'(frame_tick), 32'(m_tick));
    if (frame_tick) tick_cnt++;
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic px(int c, int r, bit v = 1'b1);
    display_col = COL_W'(c);
    display_row = ROW_W'(r);
    visible     = v;
  endtask

  task automatic set_sprite(int i, int x, int y, logic [14:0] c, bit en);
    sprite_x[i*COL_W +: COL_W] = COL_W'(x);
    sprite_y[i*ROW_W +: ROW_W] = ROW_W'(y);
    sprite_color[i*15 +: 15]   = c;
    sprite_en[i]               = en;
  endtask

  task automatic boundary();
    visible = 1'b0;
    vsync   = 1'b1;
    tick(2);
    vsync = 1'b0;
    tick(3);
    vsync = 1'b1;
    tick(2);
  endtask

  // Drive one pixel, then an idle cycle, so the pixel is on the outputs when this returns.
  task automatic show(int c, int r, bit v = 1'b1);
    px(c, r, v);
    tick();
    px(0, 0, 1'b0);
    tick();
  endtask

  task automatic check_rgb(string name, logic [7:0] r, logic [7:0] g, logic [7:0] b);
    cmp({name, ".r"}, 32'(vga_r), 32'(r));
    cmp({name, ".g"}, 32'(vga_g), 32'(g));
    cmp({name, ".b"}, 32'(vga_b), 32'(b));
  endtask

  int t0;
  int s, c, r;

  initial begin
    reset_n = 1'b0;
    px(0, 0, 1'b0);
    hsync = 1'b1;
    vsync = 1'b1;
    sprite_x = '0; sprite_y = '0; sprite_color = '0; sprite_en = '0;
    bg_tint = 9'h000;
    tick(3);
    check_rgb("reset", 8'h00, 8'h00, 8'h00);
    cmp("reset.hs", 32'(vga_hs), 32'h1);
    cmp("reset.vs", 32'(vga_vs), 32'h1);
    cmp("reset.blank_n", 32'(vga_blank_n), 32'h0);
    cmp("reset.collision", 32'(collision), 32'h0);
    reset_n = 1'b1;
    tick(2);

    // single sprite
    set_sprite(0, 100, 200, 15'h7C00, 1'b1);
    boundary();
    show(100, 200);
    check_rgb("single.hit", 8'hF8, 8'h00, 8'h00);
    cmp("single.blank_n", 32'(vga_blank_n), 32'h1);
    show(132, 200);
    check_rgb("single.right_edge", 8'h00, 8'h00, 8'h00);
    bg_tint = 9'h1FF;
    show(99, 200);
    check_rgb("bg.chk1", 8'hFF, 8'hFF, 8'hFF);
    show(132, 200);
    check_rgb("bg.chk0", 8'hE0, 8'hE0, 8'hE0);
    show(100, 200, 1'b0);
    check_rgb("blank", 8'h00, 8'h00, 8'h00);
    cmp("blank.blank_n", 32'(vga_blank_n), 32'h0);

    // priority and collision
    set_sprite(0, 0, 0, 15'h7C00, 1'b1);
    set_sprite(1, 0, 0, 15'h001F, 1'b1);
    boundary();
    t0 = tick_cnt;
    show(5, 5);
    check_rgb("priority", 8'hF8, 8'h00, 8'h00);
    boundary();
    cmp("priority.collision", 32'(collision), 32'h3);
    cmp("priority.tick_count", 32'(tick_cnt - t0), 32'h1);

    // shadow: move mid-frame, new X only after the boundary
    set_sprite(0, 300, 500, 15'h7C00, 1'b1);
    set_sprite(1, 0, 0, 15'h001F, 1'b0);
    boundary();
    show(310, 510);
    check_rgb("shadow.before", 8'hF8, 8'h00, 8'h00);
    set_sprite(0, 600, 500, 15'h7C00, 1'b1);
    show(310, 520);
    check_rgb("shadow.old_x", 8'hF8, 8'h00, 8'h00);
    show(610, 520);
    check_rgb("shadow.new_x_early", 8'hE0, 8'hE0, 8'hE0);
    boundary();
    show(610, 520);
    check_rgb("shadow.new_x", 8'hF8, 8'h00, 8'h00);
    show(310, 520);
    check_rgb("shadow.old_gone", 8'hE0, 8'hE0, 8'hE0);

    // right-edge clip
    set_sprite(0, 1270, 0, 15'h001F, 1'b1);
    boundary();
    for (int k = 1270; k <= vga_pkg::HOR_FIELD; k++) px(k, 5);
    for (int k = 1270; k <= vga_pkg::HOR_FIELD; k++) begin
      px(k, 5);
      tick();
    end
    for (int k = 0; k <= 21; k++) begin
      px(k, 5);
      tick();
    end
    px(0, 0, 1'b0);
    tick();
    check_rgb("clip.col21", 8'hE0, 8'hE0, 8'hE0);
    show(1279, 5);
    check_rgb("clip.col1279", 8'h00, 8'h00, 8'hF8);

    // reset mid-frame
    set_sprite(0, 0, 0, 15'h7C00, 1'b1);
    set_sprite(1, 0, 0, 15'h001F, 1'b1);
    boundary();
    show(5, 5);
    boundary();
    cmp("rst.pre_collision", 32'(collision), 32'h3);
    show(5, 5);
    px(5, 300);
    tick();
    reset_n = 1'b0;
    #1;
    check_rgb("rst.immediate", 8'h00, 8'h00, 8'h00);
    cmp("rst.hs", 32'(vga_hs), 32'h1);
    cmp("rst.vs", 32'(vga_vs), 32'h1);
    cmp("rst.collision", 32'(collision), 32'h0);
    cmp("rst.frame_tick", 32'(frame_tick), 32'h0);
    #1;
    tick(2);
    reset_n = 1'b1;
    t0 = tick_cnt;
    for (int k = 301; k < 310; k++) begin
      px(5, k);
      tick();
    end
    cmp("rst.no_tick_midframe", 32'(tick_cnt - t0), 32'h0);
    boundary();
    cmp("rst.tick_at_boundary", 32'(tick_cnt - t0), 32'h1);
    cmp("rst.collision_after", 32'(collision), 32'h0);

    // randomised frames
    for (int i = 0; i < NS; i++)
      set_sprite(i, $urandom_range(0, 120), $urandom_range(0, 120), 15'($urandom), 1'b1);
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < 400; k++) begin
        if (k == 200) begin
          for (int i = 0; i < NS; i++) begin
            case ($urandom % 4)
              0:       c = $urandom_range(1230, 1279);
              1:       c = $urandom_range(4070, 4095);
              default: c = $urandom_range(0, 120);
            endcase
            r = ($urandom % 3 == 0) ? $urandom_range(1000, 2047) : $urandom_range(0, 120);
            sprite_x[i*COL_W +: COL_W] = COL_W'(c);
            sprite_y[i*ROW_W +: ROW_W] = ROW_W'(r);
            sprite_en[i] = ($urandom % 4) != 0;
          end
        end
        s = $urandom % NS;
        c = int'(sprite_x[s*COL_W +: COL_W]) + $urandom_range(0, SIZE + 16) - 8;
        r = int'(sprite_y[s*ROW_W +: ROW_W]) + $urandom_range(0, SIZE + 16) - 8;
        if ($urandom % 8 == 0) c = $urandom_range(0, 40);
        px(c, r, ($urandom % 8) != 0);
        hsync = 1'($urandom);
        vsync = 1'b1;
        tick();
      end
      visible = 1'b0;
      tick(3);
      for (int i = 0; i < NS; i++) sprite_color[i*15 +: 15] = 15'($urandom);
      bg_tint = 9'($urandom);
      vsync = 1'b0;
      tick(3);
      vsync = 1'b1;
      tick(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
